// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response ports and SRAM-side strobes of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/SRAM environment.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              fe_req;
  logic [31:0]       fe_addr;
  logic              fe_gnt;
  logic              fe_rvalid;
  logic [31:0]       fe_rdata;

  logic              mem_req;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              sram_read_req;
  logic              sram_write_req;
  logic [ADDR_W-1:0] sram_addr;
  logic [3:0]        sram_byte_en;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  modport slave (
    input  fe_req, fe_addr,
    input  mem_req, mem_write, mem_addr, mem_wdata, mem_be,
    input  sram_rdata,
    output fe_gnt, fe_rvalid, fe_rdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output sram_read_req, sram_write_req, sram_addr, sram_byte_en, sram_wdata
  );

  modport master (
    output fe_req, fe_addr,
    output mem_req, mem_write, mem_addr, mem_wdata, mem_be,
    output sram_rdata,
    input  fe_gnt, fe_rvalid, fe_rdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  sram_read_req, sram_write_req, sram_addr, sram_byte_en, sram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and mem ports onto one 1-cycle-latency SRAM; mem wins, combinational grant.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  mem_port_arbiter_if.slave   io_bus
);

  logic w_fe_gnt;
  logic w_mem_gnt;
  logic w_force_fe;
  logic w_fe_rvalid;
  logic w_mem_rvalid;

  logic        r_rd_fe;
  logic        r_rd_mem;
  logic [31:0] r_fe_hold;
  logic [31:0] r_mem_hold;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve_cnt;

  assign w_force_fe = io_bus.fe_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (!io_bus.fe_req || w_fe_gnt) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_fe = 1'b0;
`endif

  // Grants are suppressed during reset so no SRAM strobe can leak out.
  always_comb begin
    w_mem_gnt = !i_reset && io_bus.mem_req && !w_force_fe;
    w_fe_gnt  = !i_reset && io_bus.fe_req && !w_mem_gnt;
  end

  assign io_bus.fe_gnt         = w_fe_gnt;
  assign io_bus.mem_gnt        = w_mem_gnt;
  assign io_bus.sram_read_req  = w_fe_gnt || (w_mem_gnt && !io_bus.mem_write);
  assign io_bus.sram_write_req = w_mem_gnt && io_bus.mem_write;
  assign io_bus.sram_addr      = w_mem_gnt ? io_bus.mem_addr[ADDR_W+1:2]
                                           : io_bus.fe_addr[ADDR_W+1:2];
  assign io_bus.sram_byte_en   = (w_mem_gnt && io_bus.mem_write) ? io_bus.mem_be : 4'b0000;
  assign io_bus.sram_wdata     = io_bus.mem_wdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_fe  <= 1'b0;
      r_rd_mem <= 1'b0;
    end else begin
      r_rd_fe  <= w_fe_gnt;
      r_rd_mem <= w_mem_gnt && !io_bus.mem_write;
    end
  end

  // A response whose read was granted just before reset is discarded here.
  assign w_fe_rvalid  = r_rd_fe  && !i_reset;
  assign w_mem_rvalid = r_rd_mem && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fe_hold  <= '0;
      r_mem_hold <= '0;
    end else begin
      if (w_fe_rvalid)  r_fe_hold  <= io_bus.sram_rdata;
      if (w_mem_rvalid) r_mem_hold <= io_bus.sram_rdata;
    end
  end

  assign io_bus.fe_rvalid  = w_fe_rvalid;
  assign io_bus.fe_rdata   = w_fe_rvalid  ? io_bus.sram_rdata : r_fe_hold;
  assign io_bus.mem_rvalid = w_mem_rvalid;
  assign io_bus.mem_rdata  = w_mem_rvalid ? io_bus.sram_rdata : r_mem_hold;

  logic w_unused;
  assign w_unused = ^{io_bus.fe_addr[31:ADDR_W+2], io_bus.fe_addr[1:0],
                      io_bus.mem_addr[31:ADDR_W+2], io_bus.mem_addr[1:0], STARVE_MAX[0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle SRAM model.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [31:0] sram [0:(1<<ADDR_W)-1];

  logic        pend_fe, pend_mem;
  logic [31:0] pend_fe_addr, pend_mem_addr;
  logic        exp_fe;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM returns filler data whenever no read was issued, so stale-data bugs show up.
  always @(posedge clk) begin
    if (bus.sram_write_req) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_byte_en[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
    end
    if (bus.sram_read_req) bus.sram_rdata <= sram[bus.sram_addr];
    else                   bus.sram_rdata <= 32'h0BAD_0BAD;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                      input logic mr, input logic mw, input logic [31:0] ma,
                      input logic [31:0] md, input logic [3:0] mb);
    @(negedge clk);
    reset          = rst;
    bus.fe_req     = fr;
    bus.fe_addr    = fa;
    bus.mem_req    = mr;
    bus.mem_write  = mw;
    bus.mem_addr   = ma;
    bus.mem_wdata  = md;
    bus.mem_be     = mb;
    #1;
    if (pend_fe && !rst) begin
      chk("proto_fe_req", {31'd0, bus.fe_req}, 32'd1);
      chk("proto_fe_addr", bus.fe_addr, pend_fe_addr);
    end
    if (pend_mem && !rst) begin
      chk("proto_mem_req", {31'd0, bus.mem_req}, 32'd1);
      chk("proto_mem_addr", bus.mem_addr, pend_mem_addr);
    end
    pend_fe       = bus.fe_req && !bus.fe_gnt && !rst;
    pend_fe_addr  = bus.fe_addr;
    pend_mem      = bus.mem_req && !bus.mem_gnt && !rst;
    pend_mem_addr = bus.mem_addr;
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pend_fe = 1'b0;
    pend_mem = 1'b0;
    pend_fe_addr = '0;
    pend_mem_addr = '0;
    for (int i = 0; i < (1<<ADDR_W); i++) sram[i] = 32'd0;
    sram[14'h040] = 32'hCAFE_0040;
    sram[14'h041] = 32'hCAFE_0041;
    sram[14'h081] = 32'hBEEF_0081;
    sram[14'h002] = 32'hFFFF_FF00;
    sram[14'h0C0] = 32'h1234_5678;
    reset = 1'b1;
    bus.fe_req = 1'b0; bus.fe_addr = '0;
    bus.mem_req = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0; bus.mem_be = '0;

    // Reset: grants and strobes blocked even with a request present
    idle(1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("rst_fe_gnt", {31'd0, bus.fe_gnt}, 32'd0);
    chk("rst_rd_strobe", {31'd0, bus.sram_read_req}, 32'd0);

    // Lone fetch read
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("rst_fe_rvalid", {31'd0, bus.fe_rvalid}, 32'd0);
    chk("rst_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    chk("rst_fe_rdata", bus.fe_rdata, 32'd0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
    chk("t1_fe_gnt", {31'd0, bus.fe_gnt}, 32'd1);
    chk("t1_mem_gnt", {31'd0, bus.mem_gnt}, 32'd0);
    chk("t1_sram_addr", {18'd0, bus.sram_addr}, 32'h040);
    chk("t1_rd_strobe", {31'd0, bus.sram_read_req}, 32'd1);
    idle(1'b0);
    chk("t1_fe_rvalid", {31'd0, bus.fe_rvalid}, 32'd1);
    chk("t1_fe_rdata", bus.fe_rdata, 32'hCAFE_0040);
    chk("t1_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);

    // Simultaneous fetch and mem read: mem first, fetch next cycle
    step(1'b0, 1'b1, 32'h104, 1'b1, 1'b0, 32'h204, 32'd0, 4'd0);
    chk("t2_mem_gnt", {31'd0, bus.mem_gnt}, 32'd1);
    chk("t2_fe_gnt0", {31'd0, bus.fe_gnt}, 32'd0);
    chk("t2_sram_addr_mem", {18'd0, bus.sram_addr}, 32'h081);
    step(1'b0, 1'b1, 32'h104, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("t2_fe_gnt1", {31'd0, bus.fe_gnt}, 32'd1);
    chk("t2_sram_addr_fe", {18'd0, bus.sram_addr}, 32'h041);
    chk("t2_mem_rvalid", {31'd0, bus.mem_rvalid}, 32'd1);
    chk("t2_mem_rdata", bus.mem_rdata, 32'hBEEF_0081);
    chk("t2_fe_rvalid0", {31'd0, bus.fe_rvalid}, 32'd0);
    idle(1'b0);
    chk("t2_fe_rvalid1", {31'd0, bus.fe_rvalid}, 32'd1);
    chk("t2_fe_rdata", bus.fe_rdata, 32'hCAFE_0041);
    chk("t2_mem_rvalid0", {31'd0, bus.mem_rvalid}, 32'd0);
    chk("t2_mem_hold", bus.mem_rdata, 32'hBEEF_0081);

    // Partial write then read-after-write of the same word
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'h0000_00AA, 4'b0001);
    chk("t4_wr_gnt", {31'd0, bus.mem_gnt}, 32'd1);
    chk("t4_wr_strobe", {31'd0, bus.sram_write_req}, 32'd1);
    chk("t4_wr_no_rd", {31'd0, bus.sram_read_req}, 32'd0);
    chk("t4_wr_be", {28'd0, bus.sram_byte_en}, 32'h1);
    chk("t4_wr_addr", {18'd0, bus.sram_addr}, 32'h002);
    chk("t4_wr_data", bus.sram_wdata, 32'h0000_00AA);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0, 4'b0001);
    chk("t4_rd_be", {28'd0, bus.sram_byte_en}, 32'h0);
    chk("t4_rd_strobe", {31'd0, bus.sram_read_req}, 32'd1);
    chk("t4_wr_no_rvalid", {31'd0, bus.mem_rvalid}, 32'd0);
    idle(1'b0);
    chk("t4_raw_rvalid", {31'd0, bus.mem_rvalid}, 32'd1);
    chk("t4_raw_rdata", bus.mem_rdata, 32'hFFFF_FFAA);
    idle(1'b0);
    chk("t4_raw_hold", bus.mem_rdata, 32'hFFFF_FFAA);

    // Mem hogging the port while fetch waits
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_fe = (i == STARVE_MAX) || (i == 2*STARVE_MAX + 1);
`else
      exp_fe = 1'b0;
`endif
      chk($sformatf("t3_fe_gnt_%0d", i), {31'd0, bus.fe_gnt}, {31'd0, exp_fe});
      chk($sformatf("t3_mem_gnt_%0d", i), {31'd0, bus.mem_gnt}, {31'd0, !exp_fe});
    end
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    chk("t3_mem_gnt_10", {31'd0, bus.mem_gnt}, 32'd1);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("t3_fe_gnt_11", {31'd0, bus.fe_gnt}, 32'd1);
    idle(1'b0);

    // Reset right after a granted fetch read
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("t5_fe_gnt", {31'd0, bus.fe_gnt}, 32'd1);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);
    chk("t5_drop_rvalid", {31'd0, bus.fe_rvalid}, 32'd0);
    chk("t5_mem_gnt", {31'd0, bus.mem_gnt}, 32'd0);
    chk("t5_wr_strobe", {31'd0, bus.sram_write_req}, 32'd0);
    chk("t5_rd_strobe", {31'd0, bus.sram_read_req}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8, 32'h55, 4'hF);
    chk("t5_rst_rvalid", {31'd0, bus.fe_rvalid}, 32'd0);
    chk("t5_rst_rdata", bus.fe_rdata, 32'd0);
    chk("t5_rst_wr_strobe", {31'd0, bus.sram_write_req}, 32'd0);
    idle(1'b0);
    chk("t5_post_rvalid", {31'd0, bus.fe_rvalid}, 32'd0);
    chk("t5_post_rdata", bus.fe_rdata, 32'd0);

    // Holding register keeps the last fetch word across idle cycles
    step(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    chk("t6_fe_gnt", {31'd0, bus.fe_gnt}, 32'd1);
    idle(1'b0);
    chk("t6_rvalid", {31'd0, bus.fe_rvalid}, 32'd1);
    chk("t6_rdata", bus.fe_rdata, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk($sformatf("t6_idle_rvalid_%0d", i), {31'd0, bus.fe_rvalid}, 32'd0);
      chk($sformatf("t6_idle_rdata_%0d", i), bus.fe_rdata, 32'h1234_5678);
    end

    // Blocked write during reset must not have reached the SRAM
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'h8, 32'd0, 4'd0);
    idle(1'b0);
    chk("t5_no_write", bus.mem_rdata, 32'hFFFF_FFAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
